// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU. Consumes a raster-order
// signed pixel stream and buffers one pooled row of horizontal maxima.
module maxpool_2x2 #(
    parameter int W    = 28,
    parameter int PP   = 8,
    parameter int RELU = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [PP:0] pxl_in,
    input  logic              in_valid,
    output logic signed [PP:0] pool_out,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int LB = (W / 2 > 0) ? W / 2 : 1;
    localparam int AW = (LB > 1) ? $clog2(LB) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0]      col_q, col_d;
    logic [CW-1:0]      row_q, row_d;
    logic signed [PP:0] h_q, h_d;
    logic signed [PP:0] pool_q, pool_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_done_q, frame_done_d;

    logic signed [PP:0] line_buf_q [LB];
    logic               lb_we;
    logic [AW-1:0]      lb_idx;
    logic signed [PP:0] lb_rd;
    logic signed [PP:0] hmax;
    logic signed [PP:0] vmax;
    logic signed [PP:0] res;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        pool_d       = pool_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        lb_idx = AW'(col_q >> 1);
        lb_rd  = line_buf_q[lb_idx];
        hmax   = (pxl_in > h_q) ? pxl_in : h_q;
        vmax   = (lb_rd > hmax) ? lb_rd : hmax;
        res    = vmax;
        if (RELU != 0 && vmax < 0) begin
            res = '0;
        end

        if (in_valid) begin
            // Even column opens a horizontal pair; odd column closes it and
            // either parks the pair max (even row) or finishes the window.
            if (!col_q[0]) begin
                h_d = pxl_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                pool_d      = res;
                out_valid_d = 1'b1;
            end

            if (col_q == LAST) begin
                col_d = '0;
                if (row_q == LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            pool_q       <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            pool_q       <= pool_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the line buffer is not reset; every entry is written on an even row
    // before the following odd row reads it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf_q[lb_idx] <= hmax;
        end
    end

    assign pool_out   = pool_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: four instances (W=4 ReLU, W=4 pass-through,
// W=28, W=5) share one pixel bus, each with its own valid and expectation queues.
module tb_maxpool_2x2;

    typedef logic signed [8:0] pix_t;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    localparam int ND = 4;
    localparam int W_OF    [ND] = '{4, 4, 28, 5};
    localparam int RELU_OF [ND] = '{1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    pix_t       pxl_in = '0;
    logic [3:0] vld = '0;
    pix_t       pool_out [ND];
    logic [3:0] out_valid;
    logic [3:0] frame_done;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Reference model state: the whole frame as received, plus raster position.
    int   frm [ND][28][28];
    int   r_m [ND];
    int   c_m [ND];
    exp_t out_q [ND][$];
    int   fd_q  [ND][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_2x2 #(.W(4), .PP(8), .RELU(1)) u_w4_relu (
        .clk(clk), .reset(reset), .pxl_in(pxl_in), .in_valid(vld[0]),
        .pool_out(pool_out[0]), .out_valid(out_valid[0]), .frame_done(frame_done[0]));
    maxpool_2x2 #(.W(4), .PP(8), .RELU(0)) u_w4_pass (
        .clk(clk), .reset(reset), .pxl_in(pxl_in), .in_valid(vld[1]),
        .pool_out(pool_out[1]), .out_valid(out_valid[1]), .frame_done(frame_done[1]));
    maxpool_2x2 #(.W(28), .PP(8), .RELU(1)) u_w28 (
        .clk(clk), .reset(reset), .pxl_in(pxl_in), .in_valid(vld[2]),
        .pool_out(pool_out[2]), .out_valid(out_valid[2]), .frame_done(frame_done[2]));
    maxpool_2x2 #(.W(5), .PP(8), .RELU(1)) u_w5 (
        .clk(clk), .reset(reset), .pxl_in(pxl_in), .in_valid(vld[3]),
        .pool_out(pool_out[3]), .out_valid(out_valid[3]), .frame_done(frame_done[3]));

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // A window's result is due on the edge accepting its bottom-right pixel.
    task automatic model_accept(input int d, input int p);
        int   r;
        int   c;
        int   m;
        exp_t e;
        r = r_m[d];
        c = c_m[d];
        frm[d][r][c] = p;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = -100000;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    if (frm[d][r-1+i][c-1+j] > m) m = frm[d][r-1+i][c-1+j];
            if (RELU_OF[d] != 0 && m < 0) m = 0;
            e.val = m;
            e.cyc = cyc + 1;
            out_q[d].push_back(e);
        end
        if (r == W_OF[d] - 1 && c == W_OF[d] - 1) fd_q[d].push_back(cyc + 1);
        c++;
        if (c == W_OF[d]) begin
            c = 0;
            r++;
            if (r == W_OF[d]) r = 0;
        end
        r_m[d] = r;
        c_m[d] = c;
    endtask

    task automatic drive(input logic [3:0] mask, input int p);
        @(posedge clk);
        #1;
        vld    = mask;
        pxl_in = pix_t'(p);
        for (int d = 0; d < ND; d++)
            if (mask[d]) model_accept(d, p);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vld    = '0;
            pxl_in = pix_t'($urandom());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        vld   = '0;
        reset = 1'b1;
        #2;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_out_valid_dut%0d", d), int'(out_valid[d]), 0);
            check($sformatf("reset_frame_done_dut%0d", d), int'(frame_done[d]), 0);
            check($sformatf("reset_pool_out_dut%0d", d), int'(pool_out[d]), 0);
            check($sformatf("drained_before_reset_dut%0d", d), out_q[d].size(), 0);
            out_q[d].delete();
            fd_q[d].delete();
            r_m[d] = 0;
            c_m[d] = 0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic ramp_frame(input logic [3:0] mask, input int offset, input bit gap);
        for (int i = 0; i < 16; i++) begin
            drive(mask, i + offset);
            if (gap) idle(1);
        end
    endtask

    // Monitor: pops one expectation per observed pulse, checking value and cycle.
    always @(negedge clk) begin
        exp_t e;
        int   fc;
        for (int d = 0; d < ND; d++) begin
            if (out_valid[d] === 1'b1) begin
                if (out_q[d].size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_out_dut%0d: got pulse value %0d at cycle %0d, expected no pulse",
                             d, pool_out[d], cyc);
                end else begin
                    e = out_q[d].pop_front();
                    check($sformatf("pool_out_dut%0d", d), int'(pool_out[d]), e.val);
                    check($sformatf("out_cycle_dut%0d", d), cyc, e.cyc);
                end
            end
            if (frame_done[d] === 1'b1) begin
                if (fd_q[d].size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_frame_done_dut%0d: got pulse at cycle %0d, expected no pulse",
                             d, cyc);
                end else begin
                    fc = fd_q[d].pop_front();
                    check($sformatf("frame_done_cycle_dut%0d", d), cyc, fc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int px [16];
        for (int d = 0; d < ND; d++) begin
            r_m[d] = 0;
            c_m[d] = 0;
        end
        repeat (2) @(posedge clk);
        do_reset();

        // Ramp frame: 5, 7, 13, 15 with frame_done on the last.
        ramp_frame(4'b0001, 0, 1'b0);
        idle(3);

        // Signed extremes in the top-left window, random elsewhere.
        for (int i = 0; i < 16; i++) px[i] = int'(pix_t'($urandom()));
        px[0] = -128;
        px[1] = 127;
        px[4] = -1;
        px[5] = 0;
        for (int i = 0; i < 16; i++) drive(4'b0001, px[i]);
        idle(3);

        // All -3 into both W=4 instances: ReLU gives 0, pass-through gives -3.
        for (int i = 0; i < 16; i++) drive(4'b0011, -3);
        idle(3);

        // Gapped ramp.
        ramp_frame(4'b0001, 0, 1'b1);
        idle(3);

        // Reset mid-frame, then a clean ramp.
        for (int i = 0; i < 6; i++) drive(4'b0001, i);
        idle(2);
        do_reset();
        ramp_frame(4'b0001, 0, 1'b0);
        idle(3);

        // Back-to-back frames with no idle cycle between them.
        ramp_frame(4'b0001, 0, 1'b0);
        ramp_frame(4'b0001, 100, 1'b0);
        idle(3);

        // W=28 random frames at a 32-wide raster rate.
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 28; r++) begin
                for (int c = 0; c < 28; c++) drive(4'b0100, int'(pix_t'($urandom())));
                idle(4);
            end

        // W=5 random frames with random gaps; trailing row/column ignored.
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 25; i++) begin
                drive(4'b1000, int'(pix_t'($urandom())));
                if ($urandom_range(0, 3) == 0) idle(1);
            end

        idle(6);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("outputs_outstanding_dut%0d", d), out_q[d].size(), 0);
            check($sformatf("frame_done_outstanding_dut%0d", d), fd_q[d].size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
